// File: rtl/lsu_pkg.sv
// Shared types, constants and helpers for the load/store unit.
//   lsu_state_t  : FSM encoding (IDLE, REQ, WAIT_RSP)
//   F3_*         : load funct3 encodings
//   BE_*         : decoder byte-enable masks for byte/half/word stores
//   norm_wr_en   : folds unknown nonzero masks onto a full word
//   is_misaligned: alignment check for one load or store
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // Zero stays zero (no store); anything other than byte/half becomes a word.
  function automatic logic [3:0] norm_wr_en(input logic [3:0] wr_en);
    logic [3:0] res;
    case (wr_en)
      4'b0000: res = 4'b0000;
      BE_B:    res = BE_B;
      BE_H:    res = BE_H;
      default: res = BE_W;
    endcase
    return res;
  endfunction

  // Loads are sized by funct3 (unused encodings act as LW), stores by wr_en.
  function automatic logic is_misaligned(input logic       is_load,
                                         input logic [3:0] wr_en,
                                         input logic [2:0] funct3,
                                         input logic [1:0] off);
    logic res;
    if (is_load) begin
      case (funct3)
        F3_LB, F3_LBU: res = 1'b0;
        F3_LH, F3_LHU: res = off[0];
        default:       res = (off != 2'b00);
      endcase
    end else begin
      case (norm_wr_en(wr_en))
        BE_H:    res = off[0];
        BE_W:    res = (off != 2'b00);
        default: res = 1'b0;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory port between the load/store unit and the memory.
//   master (LSU)   : drives mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata
//   slave (memory) : drives mem_req_ready, mem_rsp_valid, mem_rdata
interface lsu_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req_valid,
    output mem_we,
    output mem_be,
    output mem_addr,
    output mem_wdata,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req_valid,
    input  mem_we,
    input  mem_be,
    input  mem_addr,
    input  mem_wdata,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rdata
  );

endinterface

// File: rtl/lsu_load_align.sv
// Combinational load alignment: shifts the addressed byte/half down to bit 0
// and sign- or zero-extends it according to funct3.
//   rdata   : raw 32-bit memory word
//   addr_lo : byte offset within the word
//   funct3  : load width and signedness
//   result  : extended 32-bit writeback value
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  result = {24'h000000, shifted[7:0]};
      F3_LHU:  result = {16'h0000, shifted[15:0]};
      default: result = shifted;  // LW and the unused encodings
    endcase
  end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit. Turns one decoded load/store into a valid/ready
// transaction on the data-memory port, aligns load data for writeback and
// holds the pipeline with stall while a transaction is outstanding.
//   clk, rst_n         : clock, asynchronous active-low reset
//   req_*              : request from the MEM stage (req_ready high in IDLE)
//   mem                : data-memory port (lsu_if master)
//   stall              : freezes IF through MEM
//   wb_valid/rd/data   : one-cycle registered load writeback
//   misalign           : one-cycle registered misaligned-access pulse
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32  // only 32 is supported
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_load,
  input  logic [3:0]        req_wr_en,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,

  lsu_if.master             mem,

  output logic              stall,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              misalign
);

  lsu_state_t state_q, state_d;

  // Captured request context
  logic [1:0]        off_q;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q;
  logic              is_load_q;

  // Registered memory-port outputs
  logic              mem_req_valid_q;
  logic              mem_we_q;
  logic [3:0]        mem_be_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              wb_valid_q;
  logic [4:0]        wb_rd_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              misalign_q;

  logic [1:0]        req_off;
  logic [3:0]        req_be_norm;
  logic              req_active;
  logic              req_mis;
  logic              accept;
  logic              mis_hit;
  logic              store_done;
  logic              load_done;
  logic [31:0]       load_result;

  // Request decode
  assign req_off     = req_addr[1:0];
  assign req_be_norm = norm_wr_en(req_wr_en);
  // wr_en == 0 with is_load == 0 is a bubble and is silently dropped
  assign req_active  = req_is_load | (req_wr_en != 4'b0000);
  assign req_mis     = is_misaligned(req_is_load, req_wr_en, req_funct3, req_off);
  assign accept      = (state_q == IDLE) & req_valid & req_active & ~req_mis;
  assign mis_hit     = (state_q == IDLE) & req_valid & req_active & req_mis;
  assign store_done  = (state_q == REQ) & mem.mem_req_ready & ~is_load_q;
  // Responses outside WAIT_RSP (including after a reset) never count
  assign load_done   = (state_q == WAIT_RSP) & mem.mem_rsp_valid;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = REQ;
      end
      REQ: begin
        if (mem.mem_req_ready) state_d = is_load_q ? WAIT_RSP : IDLE;
      end
      WAIT_RSP: begin
        if (mem.mem_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs. stall drops in the completion cycle so the pipeline advances
  // on the same edge that retires the transaction.
  always_comb begin
    req_ready = 1'b0;
    stall     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        stall     = accept;
      end
      REQ:      stall = ~store_done;
      WAIT_RSP: stall = ~mem.mem_rsp_valid;
      default:  stall = 1'b0;
    endcase
  end

  // Request capture and memory-port registers; payload holds until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q           <= 2'b00;
      funct3_q        <= 3'b000;
      rd_q            <= 5'd0;
      is_load_q       <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_be_q        <= 4'b0000;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
    end else if (accept) begin
      off_q           <= req_off;
      funct3_q        <= req_funct3;
      rd_q            <= req_rd;
      is_load_q       <= req_is_load;
      mem_req_valid_q <= 1'b1;
      mem_we_q        <= ~req_is_load;
      mem_be_q        <= req_is_load ? BE_W : (req_be_norm << req_off);
      mem_addr_q      <= {req_addr[ADDR_W-1:2], 2'b00};
      mem_wdata_q     <= req_wdata << {req_off, 3'b000};
    end else if ((state_q == REQ) && mem.mem_req_ready) begin
      mem_req_valid_q <= 1'b0;
    end
  end

  lsu_load_align u_load_align (
    .rdata   (mem.mem_rdata),
    .addr_lo (off_q),
    .funct3  (funct3_q),
    .result  (load_result)
  );

  // Writeback and misalign strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      wb_valid_q <= load_done;
      misalign_q <= mis_hit;
      if (load_done) begin
        wb_rd_q   <= rd_q;
        wb_data_q <= load_result;
      end
    end
  end

  assign mem.mem_req_valid = mem_req_valid_q;
  assign mem.mem_we        = mem_we_q;
  assign mem.mem_be        = mem_be_q;
  assign mem.mem_addr      = mem_addr_q;
  assign mem.mem_wdata     = mem_wdata_q;

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign misalign = misalign_q;

endmodule
